// File: rtl/params.sv
// Core-wide parameters and the ALU operation encoding shared by decode and execute.
package params_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// The master modport is the surrounding pipeline; the slave modport is the decode stage.
interface decode_stage_if #(
  parameter int WORD_SIZE = params_pkg::WORD_SIZE
);

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [WORD_SIZE-1:0]   in_pc;

  logic                   out_valid;
  logic                   out_ready;
  params_pkg::alu_op_t    out_alu_op;
  logic [4:0]             out_rs1_addr;
  logic [4:0]             out_rs2_addr;
  logic [4:0]             out_rd_addr;
  logic                   out_rd_we;
  logic [WORD_SIZE-1:0]   out_imm;
  logic                   out_use_imm;
  logic                   out_use_pc;
  logic                   out_illegal;
  logic [WORD_SIZE-1:0]   out_pc;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rs1_addr, out_rs2_addr,
           out_rd_addr, out_rd_we, out_imm, out_use_imm, out_use_pc,
           out_illegal, out_pc
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_rs1_addr, out_rs2_addr,
           out_rd_addr, out_rd_we, out_imm, out_use_imm, out_use_pc,
           out_illegal, out_pc
  );

endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage for OP, OP-IMM, LUI and AUIPC with a registered valid/ready output.
// Define DECODE_SKID_BUF_EN to add a one-entry skid register that makes in_ready a pure flop.
module decode_stage #(
  parameter int WORD_SIZE = params_pkg::WORD_SIZE
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  import params_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    alu_op_t                alu_op;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic                   rd_we;
    logic [WORD_SIZE-1:0]   imm;
    logic                   use_imm;
    logic                   use_pc;
    logic                   illegal;
    logic [WORD_SIZE-1:0]   pc;
  } dec_t;

  function automatic dec_t reset_value();
    dec_t r;
    r        = '0;
    r.alu_op = ALU_ADD;
    return r;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  alu_op_t     base_op;
  alu_op_t     op_sel;
  logic        legal;
  logic        use_imm;
  logic        use_pc;
  logic        rs1_zero;
  logic [31:0] imm32;
  dec_t        dec;
  dec_t        out_reg;
  logic        out_valid;
  logic        accept;

  // Combinational decode of the offered instruction word.
  always_comb begin
    opcode   = bus.in_instr[6:0];
    funct3   = bus.in_instr[14:12];
    funct7   = bus.in_instr[31:25];
    op_sel   = ALU_ADD;
    legal    = 1'b0;
    use_imm  = 1'b0;
    use_pc   = 1'b0;
    rs1_zero = 1'b0;
    imm32    = 32'd0;

    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal  = 1'b1;
          op_sel = base_op;
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
          legal  = 1'b1;
          op_sel = ALU_SUB;
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
          legal  = 1'b1;
          op_sel = ALU_SRA;
        end else begin
          legal  = 1'b0;
          op_sel = ALU_ADD;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        // Shift-immediates carry a shamt and reuse funct7 as a qualifier.
        if (funct3 == 3'b001) begin
          legal  = (funct7 == F7_BASE);
          op_sel = ALU_SLL;
          imm32  = {27'd0, bus.in_instr[24:20]};
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE) begin
            legal  = 1'b1;
            op_sel = ALU_SRL;
          end else if (funct7 == F7_ALT) begin
            legal  = 1'b1;
            op_sel = ALU_SRA;
          end else begin
            legal  = 1'b0;
            op_sel = ALU_ADD;
          end
          imm32 = {27'd0, bus.in_instr[24:20]};
        end else begin
          legal  = 1'b1;
          op_sel = base_op;
          imm32  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        end
      end
      OPC_LUI: begin
        legal    = 1'b1;
        use_imm  = 1'b1;
        rs1_zero = 1'b1;
        imm32    = {bus.in_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        use_pc  = 1'b1;
        imm32   = {bus.in_instr[31:12], 12'd0};
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    dec         = reset_value();
    dec.rs1     = rs1_zero ? 5'd0 : bus.in_instr[19:15];
    dec.rs2     = bus.in_instr[24:20];
    dec.rd      = bus.in_instr[11:7];
    dec.pc      = bus.in_pc;
    dec.illegal = !legal;
    dec.rd_we   = legal && (bus.in_instr[11:7] != 5'd0);
    if (legal) begin
      dec.alu_op  = op_sel;
      dec.imm     = WORD_SIZE'($signed(imm32));
      dec.use_imm = use_imm;
      dec.use_pc  = use_pc;
    end else begin
      dec.alu_op  = ALU_ADD;
      dec.imm     = '0;
      dec.use_imm = 1'b0;
      dec.use_pc  = 1'b0;
    end
  end

`ifdef DECODE_SKID_BUF_EN

  dec_t skid_reg;
  logic skid_valid;
  logic in_ready_reg;
  logic load_out;

  assign bus.in_ready = in_ready_reg;
  assign accept       = bus.in_valid && in_ready_reg;
  assign load_out     = !out_valid || bus.out_ready;

  // Output register backed by one skid entry; in_ready mirrors the skid being empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_reg      <= reset_value();
      skid_valid   <= 1'b0;
      skid_reg     <= reset_value();
      in_ready_reg <= 1'b1;
    end else if (bus.flush) begin
      out_valid    <= 1'b0;
      skid_valid   <= 1'b0;
      in_ready_reg <= 1'b1;
    end else if (load_out) begin
      if (skid_valid) begin
        out_reg      <= skid_reg;
        out_valid    <= 1'b1;
        skid_valid   <= 1'b0;
        in_ready_reg <= 1'b1;
      end else if (accept) begin
        out_reg   <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_reg     <= dec;
      skid_valid   <= 1'b1;
      in_ready_reg <= 1'b0;
    end
  end

`else

  assign bus.in_ready = !out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Single output register; a new word loads whenever the slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_reg   <= reset_value();
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_reg   <= dec;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

  assign bus.out_valid    = out_valid;
  assign bus.out_alu_op   = out_reg.alu_op;
  assign bus.out_rs1_addr = out_reg.rs1;
  assign bus.out_rs2_addr = out_reg.rs2;
  assign bus.out_rd_addr  = out_reg.rd;
  assign bus.out_rd_we    = out_reg.rd_we;
  assign bus.out_imm      = out_reg.imm;
  assign bus.out_use_imm  = out_reg.use_imm;
  assign bus.out_use_pc   = out_reg.use_pc;
  assign bus.out_illegal  = out_reg.illegal;
  assign bus.out_pc       = out_reg.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a decode reference model predicts each accepted word,
// and a negedge monitor pops and compares whenever the stage hands a result to execute.
module tb_decode_stage;

  import params_pkg::*;

  typedef struct {
    alu_op_t     alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        ui;
    logic        up;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          known = 1'b0;
  int          occ = 0;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] pc = 32'h0000_1000;
  exp_t        exp_q[$];
  exp_t        mon_e;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic alu_op_t base_of(input int f3);
    case (f3)
      0: return ALU_ADD;
      1: return ALU_SLL;
      2: return ALU_SLT;
      3: return ALU_SLTU;
      4: return ALU_XOR;
      5: return ALU_SRL;
      6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Reference decode written directly from the RV32I field rules.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    int   f3;
    int   f7;
    int   opc;
    bit   alt;
    f3    = int'(w[14:12]);
    f7    = int'(w[31:25]);
    opc   = int'(w[6:0]);
    alt   = (f7 == 32);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.pc  = p;
    e.ill = 1'b1;
    e.alu = ALU_ADD;
    e.imm = 32'd0;
    e.ui  = 1'b0;
    e.up  = 1'b0;
    if (opc == 'h33) begin
      if (f7 == 0 || (alt && (f3 == 0 || f3 == 5))) begin
        e.ill = 1'b0;
        e.alu = !alt ? base_of(f3) : ((f3 == 0) ? ALU_SUB : ALU_SRA);
      end
    end else if (opc == 'h13) begin
      if (f3 != 1 && f3 != 5) begin
        e.ill = 1'b0;
        e.alu = base_of(f3);
        e.imm = 32'($signed(w[31:20]));
        e.ui  = 1'b1;
      end else if (f7 == 0 || (alt && f3 == 5)) begin
        e.ill = 1'b0;
        e.alu = alt ? ALU_SRA : base_of(f3);
        e.imm = 32'(w[24:20]);
        e.ui  = 1'b1;
      end
    end else if (opc == 'h37) begin
      e.ill = 1'b0;
      e.imm = w & 32'hFFFF_F000;
      e.ui  = 1'b1;
      e.rs1 = 5'd0;
    end else if (opc == 'h17) begin
      e.ill = 1'b0;
      e.imm = w & 32'hFFFF_F000;
      e.ui  = 1'b1;
      e.up  = 1'b1;
    end
    e.we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0, 1: w[6:0] = 7'h33;
      2, 3: w[6:0] = 7'h13;
      4:    w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
      default: w[6:0] = w[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: w[31:25] = w[31:25];
    endcase
    return w;
  endfunction

  // Monitor: every output transfer must match the oldest prediction.
  always @(negedge clk) begin
    if (known && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("alu_op",  64'(bus.out_alu_op),   64'(mon_e.alu));
        chk("rs1",     64'(bus.out_rs1_addr), 64'(mon_e.rs1));
        chk("rs2",     64'(bus.out_rs2_addr), 64'(mon_e.rs2));
        chk("rd",      64'(bus.out_rd_addr),  64'(mon_e.rd));
        chk("rd_we",   64'(bus.out_rd_we),    64'(mon_e.we));
        chk("imm",     64'(bus.out_imm),      64'(mon_e.imm));
        chk("use_imm", 64'(bus.out_use_imm),  64'(mon_e.ui));
        chk("use_pc",  64'(bus.out_use_pc),   64'(mon_e.up));
        chk("illegal", 64'(bus.out_illegal),  64'(mon_e.ill));
        chk("pc",      64'(bus.out_pc),       64'(mon_e.pc));
      end
    end
  end

  // One clock of stimulus; predicts handshakes from the stage occupancy.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic r, output logic acc);
    logic mready;
    logic consumed;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rst           = r;
    @(negedge clk);
    #1;
`ifdef DECODE_SKID_BUF_EN
    mready = (occ < 2);
`else
    mready = (occ == 0) || ordy;
`endif
    acc = 1'b0;
    if (known) begin
      chk("in_ready", 64'(bus.in_ready), 64'(mready));
      chk("out_valid", 64'(bus.out_valid), 64'(occ > 0));
      consumed = (occ > 0) && ordy;
      acc      = v && mready && !fl && !r;
      if (r || fl) begin
        occ = 0;
        exp_q.delete();
      end else begin
        if (acc) exp_q.push_back(model(w, pc));
        occ = occ + (acc ? 1 : 0) - (consumed ? 1 : 0);
      end
    end
    if (r) known = 1'b1;
    pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 8) begin
      step(1'b1, w, 1'b1, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 6 && occ > 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
    chk("drain_occ", 64'(occ), 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    chk({tag, "_alu_op"},    64'(bus.out_alu_op), 64'(ALU_ADD));
    chk({tag, "_regs"}, 64'({bus.out_rs1_addr, bus.out_rs2_addr, bus.out_rd_addr}), 64'd0);
    chk({tag, "_flags"}, 64'({bus.out_rd_we, bus.out_use_imm, bus.out_use_pc, bus.out_illegal}), 64'd0);
    chk({tag, "_imm"}, 64'(bus.out_imm), 64'd0);
    chk({tag, "_pc"},  64'(bus.out_pc),  64'd0);
  endtask

  logic [31:0] directed [10] = '{
    32'h002081B3, 32'h402081B3, 32'h40335293, 32'hFFF00093, 32'h00335293,
    32'h123453B7, 32'h00001397, 32'h00000000, 32'hFE208033, 32'h00000013
  };
  logic [31:0] burst [4] = '{32'h00208133, 32'h40418233, 32'h00C28313, 32'h0012D393};

  initial begin
    logic acc;
    int   n;
    int   k;
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, acc);
    check_reset("por");

    foreach (directed[i]) send(directed[i]);
    drain();

    n = 0;
    k = 0;
    while (n < 4 && k < 20) begin
      step(1'b1, burst[n], (k >= 3), 1'b0, 1'b0, acc);
      if (acc) n++;
      k++;
    end
    chk("burst_sent", 64'(n), 64'd4);
    drain();

    step(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00200113, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00300193, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
    send(32'h00408213);
    drain();

    step(1'b1, 32'h00500293, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00600313, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00700393, 1'b0, 1'b0, 1'b1, acc);
    check_reset("mid_rst");

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 49) == 0), 1'b0, acc);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
